// File: rtl/multicycle_addsub_if.sv
// Handshake and operand/result bundle for the chunk-serial add/sub unit.
// master = operation source / result consumer, slave = arithmetic unit.
interface multicycle_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] data_A;
  logic [WIDTH-1:0] data_B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_result;
  logic             carry_out;
  logic             overflow;
  logic             is_zero;
  logic             is_less;

  modport master (
    output in_valid, op_sub, data_A, data_B, out_ready,
    input  in_ready, out_valid, data_result, carry_out, overflow, is_zero, is_less
  );

  modport slave (
    input  in_valid, op_sub, data_A, data_B, out_ready,
    output in_ready, out_valid, data_result, carry_out, overflow, is_zero, is_less
  );
endinterface

// File: rtl/multicycle_addsub.sv
// Chunk-serial two's-complement adder/subtractor. Adds CHUNK bits per cycle,
// LSB chunk first, and reports carry, signed overflow, zero and signed less-than.
// Subtraction is A + ~B + 1: B is inverted on accept and the carry is seeded with 1.
module multicycle_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic               clock,
  input  logic               reset,
  multicycle_addsub_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bx_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             sub_q;
  logic             cout_q, ovf_q, zero_q, less_q;

  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]   sum_ch;
  logic [WIDTH-1:0] res_nxt;
  logic             ovf_nxt;
  logic             last_chunk;
  logic             in_ready_c, out_valid_c;

  function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b,
                                               input logic             cin);
    return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  endfunction

  // Current chunk sum and the full result as it will look after this edge;
  // the MSB lives in the last chunk, so flags are taken from res_nxt.
  always_comb begin
    a_ch    = a_q[int'(cnt)*CHUNK +: CHUNK];
    b_ch    = bx_q[int'(cnt)*CHUNK +: CHUNK];
    sum_ch  = chunk_add(a_ch, b_ch, carry_q);
    res_nxt = res_q;
    res_nxt[int'(cnt)*CHUNK +: CHUNK] = sum_ch[CHUNK-1:0];
    ovf_nxt = (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (res_nxt[WIDTH-1] != a_q[WIDTH-1]);
  end

  assign last_chunk = (cnt == LAST);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs; no accept in the cycle a result is taken.
  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_chunk) state_nxt = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, chunk accumulation and flag registration.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      a_q     <= '0;
      bx_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      less_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.data_A;
            bx_q    <= bus.op_sub ? ~bus.data_B : bus.data_B;
            carry_q <= bus.op_sub;
            sub_q   <= bus.op_sub;
            cnt     <= '0;
          end
        end
        RUN: begin
          res_q   <= res_nxt;
          carry_q <= sum_ch[CHUNK];
          if (last_chunk) begin
            cnt    <= '0;
            cout_q <= sum_ch[CHUNK];
            ovf_q  <= ovf_nxt;
            zero_q <= (res_nxt == '0);
            less_q <= sub_q & (res_nxt[WIDTH-1] ^ ovf_nxt);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.data_result = res_q;
  assign bus.carry_out   = cout_q;
  assign bus.overflow    = ovf_q;
  assign bus.is_zero     = zero_q;
  assign bus.is_less     = less_q;
endmodule

// File: tb/tb_multicycle_addsub.sv
// Bench for multicycle_addsub: default 32/8 instance driven from a vector
// table plus random operations, with a scoreboard queue; extra instances for
// CHUNK=WIDTH and WIDTH=24 check latency and results in other configurations.
module tb_multicycle_addsub;
  logic clk;
  logic rst;

  multicycle_addsub_if #(.WIDTH(32)) if0 ();
  multicycle_addsub_if #(.WIDTH(32)) if1 ();
  multicycle_addsub_if #(.WIDTH(24)) if2 ();

  multicycle_addsub #(.WIDTH(32), .CHUNK(8))  u0 (.clock(clk), .reset(rst), .bus(if0));
  multicycle_addsub #(.WIDTH(32), .CHUNK(32)) u1 (.clock(clk), .reset(rst), .bus(if1));
  multicycle_addsub #(.WIDTH(24), .CHUNK(8))  u2 (.clock(clk), .reset(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        l;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  vec_t sb0[$];
  vec_t last0;
  vec_t tbl[10];

  function automatic vec_t mk(input logic sub, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic c, input logic v,
                              input logic z, input logic l);
    vec_t t;
    t.sub = sub; t.a = a; t.b = b; t.res = res;
    t.c = c; t.v = v; t.z = z; t.l = l;
    return t;
  endfunction

  // Reference: full-width arithmetic, borrow-based carry, direct signed compare.
  function automatic vec_t model(input logic sub, input logic [31:0] a, input logic [31:0] b);
    vec_t t;
    logic [32:0] w;
    w = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    t.sub = sub; t.a = a; t.b = b;
    t.res = w[31:0];
    t.c   = sub ? ~w[32] : w[32];
    t.v   = sub ? ((a[31] != b[31]) && (w[31] != a[31]))
                : ((a[31] == b[31]) && (w[31] != a[31]));
    t.z   = (w[31:0] == 32'd0);
    t.l   = sub && ($signed(a) < $signed(b));
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b", name, got, exp);
    end
  endtask

  // Present an operation on u0 and wait (bounded) for the accepting edge.
  task automatic issue0(input vec_t v);
    logic rdy;
    int   n;
    if0.op_sub   = v.sub;
    if0.data_A   = v.a;
    if0.data_B   = v.b;
    if0.in_valid = 1'b1;
    n = 0;
    do begin
      rdy = if0.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 40);
    chk1("accept0", rdy, 1'b1);
    if0.in_valid = 1'b0;
    if0.data_A   = $urandom;
    if0.data_B   = $urandom;
    if0.op_sub   = 1'($urandom_range(0, 1));
    sb0.push_back(v);
  endtask

  // Count edges until out_valid, then pop the scoreboard and compare.
  task automatic wait_valid0(input int exp_lat);
    int lat;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!if0.out_valid && lat < 40);
    chk("latency0", lat, exp_lat);
    chk("sb_depth0", sb0.size(), 1);
    if (sb0.size() > 0) begin
      last0 = sb0.pop_front();
      chk ("result0",   if0.data_result, last0.res);
      chk1("carry0",    if0.carry_out,   last0.c);
      chk1("overflow0", if0.overflow,    last0.v);
      chk1("zero0",     if0.is_zero,     last0.z);
      chk1("less0",     if0.is_less,     last0.l);
    end
  endtask

  // Result handshake edge: back to IDLE, result retained.
  task automatic finish0();
    @(posedge clk); #1;
    chk1("post_valid0", if0.out_valid,   1'b0);
    chk1("post_ready0", if0.in_ready,    1'b1);
    chk ("retain0",     if0.data_result, last0.res);
  endtask

  task automatic run_vec0(input vec_t v);
    issue0(v);
    wait_valid0(4);
    finish0();
  endtask

  // One complete operation on u1 (which==1) or u2 (which==2).
  task automatic run_x(input int which, input vec_t v, input int exp_lat);
    logic rdy, ov;
    int   n;
    if (which == 1) begin
      if1.op_sub = v.sub; if1.data_A = v.a; if1.data_B = v.b; if1.in_valid = 1'b1;
    end else begin
      if2.op_sub = v.sub; if2.data_A = v.a[23:0]; if2.data_B = v.b[23:0]; if2.in_valid = 1'b1;
    end
    n = 0;
    do begin
      rdy = (which == 1) ? if1.in_ready : if2.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 40);
    chk1("accept_x", rdy, 1'b1);
    if1.in_valid = 1'b0;
    if2.in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      ov = (which == 1) ? if1.out_valid : if2.out_valid;
    end while (!ov && n < 40);
    chk("latency_x", n, exp_lat);
    chk ("result_x", (which == 1) ? if1.data_result : 32'(if2.data_result), v.res);
    chk1("carry_x",  (which == 1) ? if1.carry_out : if2.carry_out, v.c);
    chk1("ovf_x",    (which == 1) ? if1.overflow  : if2.overflow,  v.v);
    chk1("zero_x",   (which == 1) ? if1.is_zero   : if2.is_zero,   v.z);
    chk1("less_x",   (which == 1) ? if1.is_less   : if2.is_less,   v.l);
    @(posedge clk); #1;
    chk1("post_valid_x", (which == 1) ? if1.out_valid : if2.out_valid, 1'b0);
  endtask

  initial begin
    vec_t v1, v2, vr;
    int   stale;

    tbl[0] = mk(1'b1, 32'd5,          32'd3,          32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[1] = mk(1'b0, 32'h7FFFFFFF,   32'h00000001,   32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[2] = mk(1'b1, 32'd3,          32'd3,          32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[3] = mk(1'b1, 32'd0,          32'd1,          32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[4] = mk(1'b1, 32'd0,          32'h80000000,   32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[5] = mk(1'b0, 32'hFFFFFFFF,   32'h00000001,   32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[6] = mk(1'b0, 32'h000000FF,   32'h00000001,   32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[7] = mk(1'b1, 32'h80000000,   32'h00000001,   32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[8] = mk(1'b0, 32'h80000000,   32'h80000000,   32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[9] = mk(1'b1, 32'hFFFFFFFE,   32'hFFFFFFFF,   32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);

    if0.in_valid = 1'b0; if0.op_sub = 1'b0; if0.data_A = '0; if0.data_B = '0; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.op_sub = 1'b0; if1.data_A = '0; if1.data_B = '0; if1.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.op_sub = 1'b0; if2.data_A = '0; if2.data_B = '0; if2.out_ready = 1'b1;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk1("rst_in_ready0",  if0.in_ready,    1'b1);
    chk1("rst_out_valid0", if0.out_valid,   1'b0);
    chk ("rst_result0",    if0.data_result, 32'd0);
    chk1("rst_carry0",     if0.carry_out,   1'b0);
    chk1("rst_ovf0",       if0.overflow,    1'b0);
    chk1("rst_zero0",      if0.is_zero,     1'b0);
    chk1("rst_less0",      if0.is_less,     1'b0);
    chk1("rst_in_ready1",  if1.in_ready,    1'b1);
    chk ("rst_result1",    if1.data_result, 32'd0);
    chk1("rst_in_ready2",  if2.in_ready,    1'b1);
    chk ("rst_result2",    32'(if2.data_result), 32'd0);

    for (int i = 0; i < 10; i++) run_vec0(tbl[i]);

    for (int i = 0; i < 8; i++) begin
      vr = model(1'($urandom_range(0, 1)), $urandom, $urandom);
      run_vec0(vr);
    end

    // Backpressure: result held in DONE while a new operation waits.
    v1 = mk(1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 1'b0, 1'b0);
    v2 = mk(1'b1, 32'd100,      32'd42,       32'd58,       1'b1, 1'b0, 1'b0, 1'b0);
    issue0(v1);
    wait_valid0(4);
    if0.out_ready = 1'b0;
    if0.op_sub    = v2.sub;
    if0.data_A    = v2.a;
    if0.data_B    = v2.b;
    if0.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk1("bp_valid",    if0.out_valid,   1'b1);
      chk1("bp_in_ready", if0.in_ready,    1'b0);
      chk ("bp_result",   if0.data_result, v1.res);
      chk1("bp_carry",    if0.carry_out,   v1.c);
      chk1("bp_zero",     if0.is_zero,     v1.z);
    end
    if0.out_ready = 1'b1;
    @(posedge clk); #1;
    chk1("bp_release_valid", if0.out_valid, 1'b0);
    chk1("bp_idle_ready",    if0.in_ready,  1'b1);
    issue0(v2);
    wait_valid0(4);
    finish0();

    // Reset on the second RUN edge discards the operation.
    issue0(mk(1'b1, 32'd7, 32'd2, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb0.delete();
    chk1("mid_rst_in_ready",  if0.in_ready,    1'b1);
    chk1("mid_rst_out_valid", if0.out_valid,   1'b0);
    chk ("mid_rst_result",    if0.data_result, 32'd0);
    chk1("mid_rst_carry",     if0.carry_out,   1'b0);
    chk1("mid_rst_ovf",       if0.overflow,    1'b0);
    chk1("mid_rst_zero",      if0.is_zero,     1'b0);
    chk1("mid_rst_less",      if0.is_less,     1'b0);
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (if0.out_valid) stale++;
    end
    chk("mid_rst_no_valid", stale, 0);
    run_vec0(tbl[0]);

    // CHUNK == WIDTH: single-cycle RUN.
    run_x(1, tbl[0], 1);
    run_x(1, tbl[1], 1);
    run_x(1, tbl[3], 1);

    // WIDTH=24, CHUNK=8: three chunks, counter terminal value not a power of two.
    run_x(2, mk(1'b1, 32'd5,        32'd3,        32'h000002, 1'b1, 1'b0, 1'b0, 1'b0), 3);
    run_x(2, mk(1'b1, 32'd0,        32'd1,        32'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1), 3);
    run_x(2, mk(1'b0, 32'h7FFFFF,   32'h000001,   32'h800000, 1'b0, 1'b1, 1'b0, 1'b0), 3);
    run_x(2, mk(1'b0, 32'hFFFFFF,   32'h000001,   32'h000000, 1'b1, 1'b0, 1'b1, 1'b0), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_addsub.md
Name: multicycle_addsub

Overview:
- Parametrised, chunk-serial two's-complement adder/subtractor for the processor datapath.
- Generalises the fixed 32-bit operand inverter into a full add/sub unit:
  - Width is configurable.
  - The bits processed per cycle are configurable.
  - Mode (add or sub) is selected per operation.
- Produces sum/difference plus carry, overflow, zero and signed less-than flags, using a valid/ready handshake on both sides.
- Serves the ALU's multicycle path and any area-constrained arithmetic user.

Parameters:
- WIDTH, 32: operand and result width in bits. Must be ≥ 2.
- CHUNK, 8: bits added per RUN cycle. WIDTH must be an integer multiple of CHUNK. N = WIDTH/CHUNK.

Ports:
- clock, in, 1: rising-edge clock.
- reset, in, 1: synchronous, active-high reset.
- in_valid, in, 1: operands and op_sub are valid.
- in_ready, out, 1: unit can accept an operation.
- op_sub, in, 1: 0 = A+B; 1 = A-B.
- data_A, in, WIDTH: operand A.
- data_B, in, WIDTH: operand B.
- out_valid, out, 1: result and flags are valid.
- out_ready, in, 1: consumer accepts the result.
- data_result, out, WIDTH: sum or difference.
- carry_out, out, 1: carry out of the MSB. For sub, 1 means no borrow.
- overflow, out, 1: signed overflow.
- is_zero, out, 1: data_result == 0.
- is_less, out, 1: signed A < B. Meaningful only for sub; forced to 0 for add.

Behaviour:
- Reset (sampled on a rising edge with reset=1):
  - State becomes IDLE.
  - in_ready=1, out_valid=0.
  - data_result=0, carry_out=0, overflow=0, is_zero=0, is_less=0.
  - Chunk counter=0; internal operand registers cleared.
  - Reset overrides any in-flight operation in RUN or DONE; the partial result is discarded.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1:
    - Latch A.
    - Latch Bx = op_sub ? ~B : B (bitwise inversion across all WIDTH bits).
    - Set carry register = op_sub; latch op_sub.
    - Clear the counter and go to RUN.
- State RUN (lasts exactly N edges):
  - in_ready=0, out_valid=0.
  - Each edge, chunk k = counter (LSB chunk first):
    - Compute {c, s} = A[k] + Bx[k] + carry, with CHUNK+1-bit arithmetic.
    - Write s into result bits [k*CHUNK +: CHUNK].
    - carry <= c; counter++.
  - On the edge processing chunk N-1, go to DONE and register the flags:
    - carry_out = final carry.
    - overflow = (A[MSB] == Bx[MSB]) && (result[MSB] != A[MSB]).
    - is_zero = (result == 0).
    - is_less = op_sub ? (result[MSB] ^ overflow) : 0.
  - Internal result and flag registers are not visible as valid until DONE.
- State DONE:
  - out_valid=1, in_ready=0.
  - Outputs are held stable while out_ready=0, for unbounded backpressure.
  - On an edge with out_ready=1, go to IDLE.
  - Outputs retain their values after leaving DONE, but out_valid=0.
  - No new operation is accepted in the same cycle as the result handshake. Minimum issue interval is N+2 cycles.
- Latency: out_valid rises after exactly N rising edges following the accepting edge. Defaults give 4. CHUNK=WIDTH gives 1.
- Operands on data_A, data_B and op_sub may change freely after the accepting edge. Changes during RUN or DONE have no effect.
- in_valid during RUN or DONE is ignored; the source must hold it until it sees in_ready.
- Wrap-around: the result is modulo 2^WIDTH; there is no saturation.
- The counter uses ceil(log2(N)) bits, minimum 1. Its terminal value is N-1, including when N is not a power of two (e.g. WIDTH=24, CHUNK=8).

Test Plan:
- Sub 5-3:
  - Stimulus: A=5, B=3, op_sub=1, defaults.
  - Required: out_valid 4 edges after accept; result=0x00000002, carry_out=1, overflow=0, is_zero=0, is_less=0.
- Add overflow:
  - Stimulus: A=0x7FFFFFFF, B=0x00000001, op_sub=0.
  - Required: result=0x80000000, overflow=1, carry_out=0, is_less=0.
- Sub equal and borrow:
  - Stimulus 1: A=3, B=3, sub. Required: result=0, is_zero=1, carry_out=1.
  - Stimulus 2: A=0, B=1, sub. Required: result=0xFFFFFFFF, carry_out=0, is_less=1.
- Sub overflow at the MSB boundary:
  - Stimulus: A=0, B=0x80000000, sub.
  - Required: result=0x80000000, overflow=1, is_less=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands.
  - Required: result and flags unchanged; in_ready=0; second operation accepted only after return to IDLE; second result correct.
- Reset and parameters:
  - Stimulus 1: assert reset on the 2nd RUN edge. Required: next cycle in_ready=1, out_valid=0, all outputs 0; following operation correct.
  - Stimulus 2: repeat scenario 1 with CHUNK=32. Required: latency 1.
  - Stimulus 3: repeat scenario 1 with WIDTH=24, CHUNK=8. Required: latency 3, result=0x000002.
